// File: rtl/lamp_key_ctrl.sv
// Run/direction/speed controller for an LED chaser: three debounced active-low
// keys drive the mode registers, and a two-level divider produces step_tick.
module lamp_key_ctrl #(
  parameter int DEBOUNCE_CNT = 500000,
  parameter int TICK_100MS   = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_run,
  input  logic       key_dir,
  input  logic       key_spd,
  output logic       run,
  output logic       dir,
  output logic [1:0] speed,
  output logic       step_tick
);

  localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int TW = (TICK_100MS > 1) ? $clog2(TICK_100MS) : 1;
  localparam bit DEB_ONE = (DEBOUNCE_CNT < 2);
  localparam logic [DW-1:0] DEB_LAST  = DW'((DEBOUNCE_CNT >= 2) ? DEBOUNCE_CNT - 2 : 0);
  localparam logic [TW-1:0] TICK_LAST = TW'((TICK_100MS >= 1) ? TICK_100MS - 1 : 0);

  typedef enum logic [1:0] {IDLE, FILT_DN, HELD, FILT_UP} deb_state_t;

  // key index: 0 = run, 1 = dir, 2 = speed
  logic [2:0]  keys;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  press;
  deb_state_t  deb_state [3];
  logic [DW-1:0] deb_cnt [3];

  logic [TW-1:0] base_cnt;
  logic [1:0]    step_cnt;
  logic          base_strobe;

  assign keys = {key_spd, key_dir, key_run};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= keys;
      sync2 <= sync1;
    end
  end

  // The entry sample into FILT_DN counts as the first low sample, so the
  // counter only needs to reach DEBOUNCE_CNT-2 before the accepting sample;
  // press is decoded from that transition so the mode registers flip on the
  // same edge the FSM enters HELD.
  always_comb begin
    press = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      press[k] = !sync2[k] &&
                 ((deb_state[k] == IDLE && DEB_ONE) ||
                  (deb_state[k] == FILT_DN && deb_cnt[k] == DEB_LAST));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < 3; k++) begin
        deb_state[k] <= IDLE;
        deb_cnt[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 3; k++) begin
        case (deb_state[k])
          IDLE: begin
            if (!sync2[k]) begin
              deb_cnt[k]   <= '0;
              deb_state[k] <= DEB_ONE ? HELD : FILT_DN;
            end
          end
          FILT_DN: begin
            if (sync2[k])
              deb_state[k] <= IDLE;
            else if (deb_cnt[k] == DEB_LAST)
              deb_state[k] <= HELD;
            else
              deb_cnt[k] <= deb_cnt[k] + DW'(1);
          end
          HELD: begin
            if (sync2[k]) begin
              deb_cnt[k]   <= '0;
              deb_state[k] <= DEB_ONE ? IDLE : FILT_UP;
            end
          end
          FILT_UP: begin
            if (!sync2[k])
              deb_state[k] <= HELD;
            else if (deb_cnt[k] == DEB_LAST)
              deb_state[k] <= IDLE;
            else
              deb_cnt[k] <= deb_cnt[k] + DW'(1);
          end
          default: deb_state[k] <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run   <= 1'b1;
      dir   <= 1'b0;
      speed <= '0;
    end else begin
      run   <= run ^ press[0];
      dir   <= dir ^ press[1];
      speed <= speed + {1'b0, press[2]};
    end
  end

  assign base_strobe = run && (base_cnt == TICK_LAST);

  // A speed change restarts the step count but leaves the base phase alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_cnt  <= '0;
      step_cnt  <= '0;
      step_tick <= 1'b0;
    end else begin
      step_tick <= base_strobe && (step_cnt == speed);
      if (run)
        base_cnt <= base_strobe ? '0 : base_cnt + TW'(1);
      if (press[2])
        step_cnt <= '0;
      else if (base_strobe)
        step_cnt <= (step_cnt == speed) ? '0 : step_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_lamp_key_ctrl.sv
// Bench for lamp_key_ctrl: directed key scenarios plus random key activity,
// checked every cycle against a level/run-length key model and a clock-count tick model.
module tb_lamp_key_ctrl;

  localparam int DC = 4;
  localparam int T  = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_run = 1'b1;
  logic       key_dir = 1'b1;
  logic       key_spd = 1'b1;
  logic       run;
  logic       dir;
  logic [1:0] speed;
  logic       step_tick;

  lamp_key_ctrl #(.DEBOUNCE_CNT(DC), .TICK_100MS(T)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_run   (key_run),
    .key_dir   (key_dir),
    .key_spd   (key_spd),
    .run       (run),
    .dir       (dir),
    .speed     (speed),
    .step_tick (step_tick)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: each key has an accepted level that flips after DC consecutive
  // opposite samples, seen two edges after the pin is sampled.
  bit m_run, m_dir, m_tick;
  int m_spd, m_base, m_step;
  bit lvl [3];
  bit p1 [3];
  bit p2 [3];
  int len [3];

  task automatic model_reset();
    m_run = 1'b1; m_dir = 1'b0; m_spd = 0; m_base = 0; m_step = 0; m_tick = 1'b0;
    for (int k = 0; k < 3; k++) begin
      lvl[k] = 1'b1; p1[k] = 1'b1; p2[k] = 1'b1; len[k] = 0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, ".run"},  run,       1);
    check_eq({tag, ".dir"},  dir,       0);
    check_eq({tag, ".spd"},  speed,     0);
    check_eq({tag, ".tick"}, step_tick, 0);
  endtask

  task automatic cycle(input bit kr, input bit kd, input bit ks, input string tag);
    bit pin [3];
    bit pr [3];
    bit samp;
    bit strobe;
    key_run = kr; key_dir = kd; key_spd = ks;
    @(posedge clk);
    pin = '{kr, kd, ks};
    for (int k = 0; k < 3; k++) begin
      samp  = p2[k];
      p2[k] = p1[k];
      p1[k] = pin[k];
      pr[k] = 1'b0;
      if (samp != lvl[k]) begin
        len[k]++;
        if (len[k] == DC) begin
          lvl[k] = samp;
          len[k] = 0;
          pr[k]  = !samp;
        end
      end else begin
        len[k] = 0;
      end
    end
    strobe = m_run && (m_base == T - 1);
    m_tick = strobe && (m_step == m_spd);
    if (m_run) m_base = (m_base + 1) % T;
    if (pr[2]) m_step = 0;
    else if (strobe) m_step = (m_step == m_spd) ? 0 : m_step + 1;
    if (pr[0]) m_run = !m_run;
    if (pr[1]) m_dir = !m_dir;
    if (pr[2]) m_spd = (m_spd + 1) % 4;
    #1;
    check_eq({tag, ".run"},  run,       m_run);
    check_eq({tag, ".dir"},  dir,       m_dir);
    check_eq({tag, ".spd"},  speed,     m_spd);
    check_eq({tag, ".tick"}, step_tick, m_tick);
  endtask

  initial begin
    int first;
    int first2;
    int last;
    bit kr, kd, ks;

    // reset, then idle ticking at speed 0
    rst_n = 1'b0;
    #12;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    first = -1;
    for (int i = 1; i <= 12; i++) begin
      cycle(1, 1, 1, "idle");
      if (first < 0 && step_tick === 1'b1) first = i;
    end
    check_eq("first_tick", first, T);

    // speed press held: one increment after DC+1 edges, then 10-clock period
    first = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 1, 0, "spd_hold");
      if (first < 0 && speed === 2'd1) first = i;
    end
    check_eq("spd_latency", first, DC + 1);
    check_eq("spd_once", speed, 1);
    last = -1;
    for (int i = 0; i < 45; i++) begin
      cycle(1, 1, 1, "spd1");
      if (step_tick === 1'b1) begin
        if (last >= 0) check_eq("spd1_period", i - last, 10);
        last = i;
      end
    end

    // bouncing dir key never accepted
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, "bounce");
    cycle(1, 1, 1, "bounce");
    for (int i = 0; i < 3; i++) cycle(1, 0, 1, "bounce");
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, "bounce");
    check_eq("bounce_dir", dir, 0);

    // pause and resume
    first = -1;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 1, 1, "pause");
      if (first < 0 && run === 1'b0) first = i;
    end
    check_eq("pause_latency", first, DC + 1);
    for (int i = 0; i < 15; i++) cycle(1, 1, 1, "paused");
    for (int i = 0; i < 10; i++) cycle(0, 1, 1, "resume");
    for (int i = 0; i < 30; i++) cycle(1, 1, 1, "resumed");
    check_eq("resumed_run", run, 1);

    // simultaneous run and speed presses land on the same edge
    first = -1; first2 = -1;
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 0, "dual");
      if (first < 0 && run === 1'b0) first = i;
      if (first2 < 0 && speed === 2'd2) first2 = i;
    end
    check_eq("dual_run", first, DC + 1);
    check_eq("dual_spd", first2, DC + 1);
    for (int i = 0; i < 10; i++) cycle(1, 1, 1, "dual_rel");

    // reset in the middle of a dir filter: no late toggle
    for (int i = 0; i < 5; i++) cycle(1, 0, 1, "mid_filt");
    #1;
    rst_n = 1'b0;
    key_dir = 1'b1;
    #1;
    check_reset_vals("async_rst");
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals("held_rst");
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) cycle(1, 1, 1, "post_rst");
    check_eq("post_rst_dir", dir, 0);

    // random key activity with bursts and bounces
    kr = 1'b1; kd = 1'b1; ks = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(9) == 0) kr = !kr;
      if ($urandom_range(9) == 0) kd = !kd;
      if ($urandom_range(9) == 0) ks = !ks;
      cycle(kr, kd, ks, "rand");
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
